// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: load-use and branch-compare stall sequencing,
// taken-branch flush, dmem wait freeze and saturating perf counters.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef BEQ
`define BEQ 7'b1100011
`endif

module hazard_stall_controller #(
  parameter int REG_ADDR_WIDTH = `REG_ADDR_WIDTH,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [6:0]                IF_ID_inst_opcode,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
  input  logic                      ID_EX_mem_rd_en,
  input  logic                      ID_EX_reg_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
  input  logic                      EX_MEM_mem_rd_en,
  input  logic [REG_ADDR_WIDTH-1:0] EX_MEM_rd,
  input  logic                      branch_taken,
  input  logic                      dmem_req,
  input  logic                      dmem_ready,
  input  logic                      clr_cnt,
  output logic                      pc_wr_en,
  output logic                      IF_ID_wr_en,
  output logic                      IF_ID_flush,
  output logic                      ID_EX_bubble,
  output logic                      pipe_hold,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt,
  output logic [CNT_WIDTH-1:0]      wait_cnt
);

  typedef enum logic [1:0] {
    RUN,
    STALL,
    MEM_WAIT
  } state_e;

  state_e state_q, state_d;
  state_e ret_q, ret_d;
  state_e cur;
  logic [1:0] left_q, left_d;
  logic [CNT_WIDTH-1:0] stall_q, flush_q, wait_q;

  logic inc_stall, inc_flush, inc_wait;
  logic pc_en, ifid_en, flush, bubble, hold;

  logic mem_wait, is_br;
  logic load_use, br_mem, br_ex;
  logic unused_reg_wr;

  // ALU producers are forwarded, so the write-enable never matters here.
  assign unused_reg_wr = ID_EX_reg_wr_en;

  assign mem_wait = dmem_req & ~dmem_ready;
  assign is_br    = (IF_ID_inst_opcode == `BEQ);

  assign load_use = ID_EX_mem_rd_en
                  & (ID_EX_rd != '0)
                  & ((ID_EX_rd == IF_ID_rs1)
                   | (ID_EX_rd == IF_ID_rs2));

  assign br_ex  = is_br & load_use;

  assign br_mem = is_br
                & EX_MEM_mem_rd_en
                & (EX_MEM_rd != '0)
                & ((EX_MEM_rd == IF_ID_rs1)
                 | (EX_MEM_rd == IF_ID_rs2));

  // Next state, stall budget and control outputs; MEM_WAIT replays
  // the saved state as soon as the memory stops stalling.
  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    left_d    = left_q;
    pc_en     = 1'b0;
    ifid_en   = 1'b0;
    flush     = 1'b0;
    bubble    = 1'b0;
    hold      = 1'b0;
    inc_stall = 1'b0;
    inc_flush = 1'b0;
    inc_wait  = 1'b0;
    cur       = (state_q == MEM_WAIT) ? ret_q : state_q;

    if (mem_wait) begin
      hold     = 1'b1;
      state_d  = MEM_WAIT;
      ret_d    = cur;
      inc_wait = 1'b1;
    end else begin
      state_d = cur;
      unique case (cur)
        STALL: begin
          bubble    = 1'b1;
          inc_stall = 1'b1;
          if (left_q <= 2'd1) begin
            left_d  = 2'd0;
            state_d = RUN;
          end else begin
            left_d  = left_q - 2'd1;
          end
        end
        default: begin
          if (load_use | br_mem) begin
            bubble    = 1'b1;
            inc_stall = 1'b1;
            if (br_ex) begin
              left_d  = 2'd1;
              state_d = STALL;
            end else begin
              left_d  = 2'd0;
              state_d = RUN;
            end
          end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
            if (is_br & branch_taken) begin
              flush     = 1'b1;
              inc_flush = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // FSM state, saved return state and remaining stall cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      ret_q   <= RUN;
      left_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      left_q  <= left_d;
    end
  end

  // Saturating counters; a clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      stall_q <= '0;
      flush_q <= '0;
      wait_q  <= '0;
    end else begin
      if (inc_stall && stall_q != '1)
        stall_q <= stall_q + CNT_WIDTH'(1);
      if (inc_flush && flush_q != '1)
        flush_q <= flush_q + CNT_WIDTH'(1);
      if (inc_wait && wait_q != '1)
        wait_q <= wait_q + CNT_WIDTH'(1);
    end
  end

  assign pc_wr_en     = rst_n & pc_en;
  assign IF_ID_wr_en  = rst_n & ifid_en;
  assign IF_ID_flush  = rst_n & flush;
  assign ID_EX_bubble = rst_n & bubble;
  assign pipe_hold    = rst_n & hold;
  assign stall_cnt    = rst_n ? stall_q : '0;
  assign flush_cnt    = rst_n ? flush_q : '0;
  assign wait_cnt     = rst_n ? wait_q : '0;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: directed checks of stall, flush,
// memory-wait freeze, reset abort and counter saturation/clear.
module tb_hazard_stall_controller;

  localparam int RW = 5;
  localparam int CW = 2;
  localparam logic [6:0] BEQ_OP = 7'b1100011;
  localparam logic [6:0] ALU_OP = 7'b0110011;

  // {pc_wr_en, IF_ID_wr_en, IF_ID_flush, ID_EX_bubble, pipe_hold}
  localparam logic [4:0] C_RUN = 5'b11000;
  localparam logic [4:0] C_BUB = 5'b00010;
  localparam logic [4:0] C_FLU = 5'b11100;
  localparam logic [4:0] C_HLD = 5'b00001;
  localparam logic [4:0] C_OFF = 5'b00000;

  logic clk = 1'b0;
  logic rst_n;
  logic [6:0] op;
  logic [RW-1:0] rs1, rs2, ex_rd, mem_rd;
  logic ex_ld, ex_wr, mem_ld;
  logic br_tk, dreq, drdy, clr;
  logic pc_wr_en, IF_ID_wr_en, IF_ID_flush;
  logic ID_EX_bubble, pipe_hold;
  logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt;
  logic [4:0] ctl;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_wr_en, IF_ID_wr_en, IF_ID_flush,
                ID_EX_bubble, pipe_hold};

  hazard_stall_controller #(
    .REG_ADDR_WIDTH(RW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .IF_ID_inst_opcode(op),
    .IF_ID_rs1(rs1),
    .IF_ID_rs2(rs2),
    .ID_EX_mem_rd_en(ex_ld),
    .ID_EX_reg_wr_en(ex_wr),
    .ID_EX_rd(ex_rd),
    .EX_MEM_mem_rd_en(mem_ld),
    .EX_MEM_rd(mem_rd),
    .branch_taken(br_tk),
    .dmem_req(dreq),
    .dmem_ready(drdy),
    .clr_cnt(clr),
    .pc_wr_en(pc_wr_en),
    .IF_ID_wr_en(IF_ID_wr_en),
    .IF_ID_flush(IF_ID_flush),
    .ID_EX_bubble(ID_EX_bubble),
    .pipe_hold(pipe_hold),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt),
    .wait_cnt(wait_cnt)
  );

  task automatic idle();
    op = ALU_OP; rs1 = '0; rs2 = '0;
    ex_ld = 0; ex_wr = 0; ex_rd = '0;
    mem_ld = 0; mem_rd = '0;
    br_tk = 0; dreq = 0; drdy = 0; clr = 0;
  endtask

  task automatic clear_counters();
    @(negedge clk);
    idle();
    clr = 1;
    @(negedge clk);
    clr = 0;
  endtask

  // BEQ in ID reading rs2=7 while a load to x7 sits in EX.
  task automatic br_ex_setup();
    idle();
    op = BEQ_OP; rs1 = 5'd3; rs2 = 5'd7;
    ex_ld = 1; ex_wr = 1; ex_rd = 5'd7;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle();
    rst_n = 0;
    ex_ld = 1; ex_rd = 5'd5; rs1 = 5'd5;
    #1;
    checks++;
    if (ctl !== C_OFF) begin
      errors++;
      $display("FAIL reset_ctl got=%b exp=%b", ctl, C_OFF);
    end
    @(negedge clk);
    idle();
    rst_n = 1;
    #1;
    checks++;
    if ({stall_cnt, flush_cnt, wait_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_cnt got=%h exp=0",
               {stall_cnt, flush_cnt, wait_cnt});
    end
    checks++;
    if (ctl !== C_RUN) begin
      errors++;
      $display("FAIL reset_run got=%b exp=%b", ctl, C_RUN);
    end
  endtask

  task automatic test_load_use();
    clear_counters();
    ex_ld = 1; ex_wr = 1; ex_rd = 5'd5; rs1 = 5'd5;
    #1;
    checks++;
    if (ctl !== C_BUB) begin
      errors++;
      $display("FAIL lu_bubble got=%b exp=%b", ctl, C_BUB);
    end
    @(negedge clk);
    idle();
    mem_ld = 1; mem_rd = 5'd5; rs1 = 5'd5;
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      errors++;
      $display("FAIL lu_after got=%b exp=%b", ctl, C_RUN);
    end
    checks++;
    if (stall_cnt !== 2'd1) begin
      errors++;
      $display("FAIL lu_cnt got=%0d exp=1", stall_cnt);
    end
    @(negedge clk);
    idle();
    ex_ld = 1; ex_rd = 5'd9; rs2 = 5'd9;
    #1;
    checks++;
    if (ctl !== C_BUB) begin
      errors++;
      $display("FAIL lu_rs2 got=%b exp=%b", ctl, C_BUB);
    end
    @(negedge clk);
    idle();
    ex_wr = 1; ex_rd = 5'd9; rs1 = 5'd9;
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      errors++;
      $display("FAIL lu_alu got=%b exp=%b", ctl, C_RUN);
    end
  endtask

  task automatic test_branch_ex();
    clear_counters();
    br_ex_setup();
    br_tk = 1;
    #1;
    checks++;
    if (ctl !== C_BUB) begin
      errors++;
      $display("FAIL bex_b1 got=%b exp=%b", ctl, C_BUB);
    end
    @(negedge clk);
    ex_ld = 0; ex_wr = 0; ex_rd = '0;
    mem_ld = 1; mem_rd = 5'd7;
    br_tk = 1;
    #1;
    checks++;
    if (ctl !== C_BUB) begin
      errors++;
      $display("FAIL bex_b2 got=%b exp=%b", ctl, C_BUB);
    end
    @(negedge clk);
    mem_ld = 0; mem_rd = '0;
    br_tk = 1;
    #1;
    checks++;
    if (ctl !== C_FLU) begin
      errors++;
      $display("FAIL bex_flush got=%b exp=%b", ctl, C_FLU);
    end
    checks++;
    if (stall_cnt !== 2'd2) begin
      errors++;
      $display("FAIL bex_cnt got=%0d exp=2", stall_cnt);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (flush_cnt !== 2'd1) begin
      errors++;
      $display("FAIL flush_cnt got=%0d exp=1", flush_cnt);
    end
    op = BEQ_OP; ex_ld = 1; ex_rd = '0;
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      errors++;
      $display("FAIL bex_rd0 got=%b exp=%b", ctl, C_RUN);
    end
  endtask

  task automatic test_branch_mem();
    clear_counters();
    op = BEQ_OP; rs1 = 5'd9;
    mem_ld = 1; mem_rd = 5'd9;
    #1;
    checks++;
    if (ctl !== C_BUB) begin
      errors++;
      $display("FAIL bmem_b got=%b exp=%b", ctl, C_BUB);
    end
    @(negedge clk);
    mem_ld = 0; mem_rd = '0;
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      errors++;
      $display("FAIL bmem_run got=%b exp=%b", ctl, C_RUN);
    end
    checks++;
    if (stall_cnt !== 2'd1) begin
      errors++;
      $display("FAIL bmem_cnt got=%0d exp=1", stall_cnt);
    end
    @(negedge clk);
    idle();
    op = ALU_OP; rs1 = 5'd9;
    mem_ld = 1; mem_rd = 5'd9;
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      errors++;
      $display("FAIL bmem_nobr got=%b exp=%b", ctl, C_RUN);
    end
  endtask

  task automatic test_mem_wait();
    clear_counters();
    br_ex_setup();
    #1;
    checks++;
    if (ctl !== C_BUB) begin
      errors++;
      $display("FAIL mw_b1 got=%b exp=%b", ctl, C_BUB);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ex_ld = 0; ex_rd = '0;
      dreq = 1; drdy = 0;
      #1;
      checks++;
      if (ctl !== C_HLD) begin
        errors++;
        $display("FAIL mw_hold%0d got=%b exp=%b", i, ctl, C_HLD);
      end
    end
    @(negedge clk);
    dreq = 1; drdy = 1;
    #1;
    checks++;
    if (ctl !== C_BUB) begin
      errors++;
      $display("FAIL mw_b2 got=%b exp=%b", ctl, C_BUB);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      errors++;
      $display("FAIL mw_run got=%b exp=%b", ctl, C_RUN);
    end
    checks++;
    if ({stall_cnt, wait_cnt} !== {2'd2, 2'd3}) begin
      errors++;
      $display("FAIL mw_cnt got=%0d/%0d exp=2/3",
               stall_cnt, wait_cnt);
    end
    br_ex_setup();
    dreq = 1; drdy = 0;
    #1;
    checks++;
    if (ctl !== C_HLD) begin
      errors++;
      $display("FAIL mw_prio got=%b exp=%b", ctl, C_HLD);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      errors++;
      $display("FAIL mw_ret got=%b exp=%b", ctl, C_RUN);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    br_ex_setup();
    #1;
    checks++;
    if (ctl !== C_BUB) begin
      errors++;
      $display("FAIL rm_b1 got=%b exp=%b", ctl, C_BUB);
    end
    @(negedge clk);
    idle();
    rst_n = 0;
    #1;
    checks++;
    if (ctl !== C_OFF) begin
      errors++;
      $display("FAIL rm_off got=%b exp=%b", ctl, C_OFF);
    end
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      errors++;
      $display("FAIL rm_run got=%b exp=%b", ctl, C_RUN);
    end
    checks++;
    if (stall_cnt !== 2'd0) begin
      errors++;
      $display("FAIL rm_cnt got=%0d exp=0", stall_cnt);
    end
  endtask

  task automatic test_saturation();
    clear_counters();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      idle();
      ex_ld = 1; ex_rd = 5'd4; rs2 = 5'd4;
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (stall_cnt !== 2'd3) begin
      errors++;
      $display("FAIL sat_cnt got=%0d exp=3", stall_cnt);
    end
    ex_ld = 1; ex_rd = 5'd4; rs2 = 5'd4;
    clr = 1;
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (stall_cnt !== 2'd0) begin
      errors++;
      $display("FAIL clr_wins got=%0d exp=0", stall_cnt);
    end
  endtask

  initial begin
    idle();
    rst_n = 0;
    test_reset();
    test_load_use();
    test_branch_ex();
    test_branch_mem();
    test_mem_wait();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
